// File: rtl/voice_alloc_pkg.sv
// voice_alloc_pkg: slot state encoding, default sizes and the
// note-event bundle shared by the voice allocator files.
package voice_alloc_pkg;

  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_KEY_W      = 7;

  typedef enum logic [3:0] {
    S_FREE  = 4'b0001,
    S_START = 4'b0010,
    S_HELD  = 4'b0100,
    S_REL   = 4'b1000
  } slot_state_t;

  typedef struct packed {
    logic                 on;
    logic [DEF_KEY_W-1:0] key;
  } note_ev_t;

endpackage

// File: rtl/voice_slot.sv
// voice_slot: one voice FSM (FREE/START/HELD/RELEASING) with key latch,
// pending-release flag and registered note_on/note_off levels.
// Ports: clk, rst_b, alloc, rel, busy, key_in -> state, active_nxt,
//        key, note_on, note_off.
module voice_slot
  import voice_alloc_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             alloc,
  input  logic             rel,
  input  logic             busy,
  input  logic [KEY_W-1:0] key_in,
  output logic [3:0]       state,
  output logic             active_nxt,
  output logic [KEY_W-1:0] key,
  output logic             note_on,
  output logic             note_off
);

  slot_state_t st, nxt;
  logic        rel_pend, pend_nxt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      st       <= S_FREE;
      rel_pend <= 1'b0;
      key      <= '0;
      note_on  <= 1'b0;
      note_off <= 1'b0;
    end else begin
      st       <= nxt;
      rel_pend <= pend_nxt;
      note_on  <= (nxt == S_START);
      note_off <= (nxt == S_REL);
      if (alloc && st == S_FREE)
        key <= key_in;
    end
  end

  // A release that lands in the same cycle busy rises is
  // honoured directly instead of being parked in rel_pend.
  always_comb begin
    nxt      = st;
    pend_nxt = rel_pend;
    unique case (st)
      S_FREE:
        if (alloc) begin
          nxt      = S_START;
          pend_nxt = 1'b0;
        end
      S_START:
        if (busy) begin
          nxt      = (rel_pend || rel) ? S_REL : S_HELD;
          pend_nxt = 1'b0;
        end else if (rel) begin
          pend_nxt = 1'b1;
        end
      S_HELD:
        if (rel) nxt = S_REL;
      S_REL:
        if (!busy) nxt = S_FREE;
      default:
        nxt = S_FREE;
    endcase
  end

  assign state      = st;
  assign active_nxt = (nxt != S_FREE);

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: binds note events to envelope voices (lowest free
// voice, no retrigger, LRU ranks). Ports: clk, rst_b, ev_valid/ev_ready,
// ev_on, ev_key, voice_busy -> voice_note_on/off, voice_key, active_count.
// Option: VOICE_ALLOC_STEAL_EN steals the oldest HELD voice on a stall.
module voice_allocator
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int KEY_W      = DEF_KEY_W,
  parameter int CNT_W      = 5
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        ev_valid,
  output logic                        ev_ready,
  input  logic                        ev_on,
  input  logic [KEY_W-1:0]            ev_key,
  input  logic [NUM_VOICES-1:0]       voice_busy,
  output logic [NUM_VOICES-1:0]       voice_note_on,
  output logic [NUM_VOICES-1:0]       voice_note_off,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [CNT_W-1:0]            active_count
);

  localparam int RW = $clog2(NUM_VOICES);

  logic [3:0]            st     [NUM_VOICES];
  logic [KEY_W-1:0]      key_of [NUM_VOICES];
  logic [RW-1:0]         rank   [NUM_VOICES];
  logic [RW-1:0]         chosen;
  logic [NUM_VOICES-1:0] act_nxt, alloc, rel, rel_ev;
  logic [NUM_VOICES-1:0] free_v, match, pick;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  accept;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot #(.KEY_W(KEY_W)) u_slot (
      .clk        (clk),
      .rst_b      (rst_b),
      .alloc      (alloc[i]),
      .rel        (rel[i]),
      .busy       (voice_busy[i]),
      .key_in     (ev_key),
      .state      (st[i]),
      .active_nxt (act_nxt[i]),
      .key        (key_of[i]),
      .note_on    (voice_note_on[i]),
      .note_off   (voice_note_off[i])
    );
    assign voice_key[i*KEY_W +: KEY_W] = key_of[i];
  end

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      free_v[i] = (st[i] == S_FREE) && !voice_busy[i];
      match[i]  = (st[i] == S_START || st[i] == S_HELD) &&
                  (key_of[i] == ev_key);
    end
  end

  // One-hot lowest-index free voice.
  always_comb begin
    pick = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--)
      if (free_v[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
  end

  assign ev_ready = !ev_on || (|match) || (|free_v);
  assign accept   = ev_valid && ev_ready;
  assign alloc    = (accept && ev_on && !(|match)) ? pick : '0;
  assign rel_ev   = (accept && !ev_on) ? match : '0;

`ifdef VOICE_ALLOC_STEAL_EN
  logic [NUM_VOICES-1:0] steal;
  logic [RW-1:0]         best;
  logic                  any_rel;

  // A RELEASING voice means a steal (or natural release) is
  // already underway, so at most one steal is outstanding.
  always_comb begin
    steal   = '0;
    best    = '0;
    any_rel = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (st[i] == S_REL) any_rel = 1'b1;
    if (ev_valid && ev_on && !ev_ready && !any_rel)
      for (int i = 0; i < NUM_VOICES; i++)
        if (st[i] == S_HELD && (!(|steal) || rank[i] > best)) begin
          steal    = '0;
          steal[i] = 1'b1;
          best     = rank[i];
        end
  end

  assign rel = rel_ev | steal;
`else
  assign rel = rel_ev;
`endif

  always_comb begin
    chosen = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (alloc[i]) chosen = rank[i];
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NUM_VOICES; i++)
        rank[i] <= RW'(i);
    end else if (|alloc) begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (alloc[i])
          rank[i] <= '0;
        else if (rank[i] < chosen)
          rank[i] <= rank[i] + RW'(1);
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      cnt_nxt = cnt_nxt + CNT_W'(act_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) active_count <= '0;
    else        active_count <= cnt_nxt;
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed scoreboard bench for voice_allocator
// with a simple envelope busy model per voice.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int KW = 7;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_b = 1'b1;
  logic          ev_valid = 1'b0;
  logic          ev_on = 1'b0;
  logic [KW-1:0] ev_key = '0;
  logic          ev_ready;
  logic [NV-1:0] voice_busy;
  logic [NV-1:0] voice_note_on;
  logic [NV-1:0] voice_note_off;
  logic [NV*KW-1:0] voice_key;
  logic [CW-1:0] active_count;

  always #5 clk = ~clk;

  voice_allocator #(
    .NUM_VOICES(NV), .KEY_W(KW), .CNT_W(CW)
  ) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_on          (ev_on),
    .ev_key         (ev_key),
    .voice_busy     (voice_busy),
    .voice_note_on  (voice_note_on),
    .voice_note_off (voice_note_off),
    .voice_key      (voice_key),
    .active_count   (active_count)
  );

  // Envelope model: busy rises one cycle after note_on,
  // falls one cycle after note_off.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) voice_busy <= '0;
    else
      for (int i = 0; i < NV; i++)
        if (voice_note_on[i])       voice_busy[i] <= 1'b1;
        else if (voice_note_off[i]) voice_busy[i] <= 1'b0;
  end

  typedef struct {
    int v;
    int key;
  } exp_t;

  exp_t on_q[$];
  exp_t off_q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic int key_of(int v);
    return int'(voice_key[v*KW +: KW]);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  logic [NV-1:0] prev_on = '0;
  logic [NV-1:0] prev_off = '0;

  // Monitor: every note_on / note_off rise consumes one expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NV; i++) begin
      if (voice_note_on[i] && !prev_on[i]) begin
        if (on_q.size() == 0) check("on_unexpected", i, -1);
        else begin
          e = on_q.pop_front();
          check("on_voice", i, e.v);
          check("on_key", key_of(i), e.key);
        end
      end
      if (voice_note_off[i] && !prev_off[i]) begin
        if (off_q.size() == 0) check("off_unexpected", i, -1);
        else begin
          e = off_q.pop_front();
          check("off_voice", i, e.v);
          check("off_key", key_of(i), e.key);
        end
      end
    end
    prev_on  = voice_note_on;
    prev_off = voice_note_off;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one event and holds it until accepted (bounded).
  task automatic send(input bit on, input int key, output int waited);
    ev_on    = on;
    ev_key   = KW'(key);
    ev_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!ev_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!ev_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    #2 rst_b = 1'b0;
    tick(2);
    check("rst_note_on", int'(voice_note_on), 0);
    check("rst_note_off", int'(voice_note_off), 0);
    check("rst_key", int'(voice_key), 0);
    check("rst_count", int'(active_count), 0);
    rst_b = 1'b1;
    tick(1);

    // single note-on
    on_q.push_back('{0, 60});
    send(1'b1, 60, w);
    check("t1_wait", w, 0);
    check("t1_start_on", int'(voice_note_on[0]), 1);
    tick(2);
    check("t1_held_on", int'(voice_note_on[0]), 0);
    check("t1_key", key_of(0), 60);
    check("t1_count", int'(active_count), 1);

    // fill all voices, stall, release voice 1
    on_q.push_back('{1, 62});
    send(1'b1, 62, w);
    on_q.push_back('{2, 64});
    send(1'b1, 64, w);
    on_q.push_back('{3, 65});
    send(1'b1, 65, w);
    tick(3);
    check("t2_count_full", int'(active_count), 4);
`ifndef VOICE_ALLOC_STEAL_EN
    ev_on    = 1'b1;
    ev_key   = KW'(67);
    ev_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t2_stall", int'(ev_ready), 0);
    end
    @(posedge clk);
    #1 ev_valid = 1'b0;
`endif
    off_q.push_back('{1, 62});
    send(1'b0, 62, w);
    check("t2_off_wait", w, 0);
    on_q.push_back('{1, 67});
    send(1'b1, 67, w);
    check("t2_67_wait", w, 2);
    tick(3);
    check("t2_key1", key_of(1), 67);
    check("t2_count", int'(active_count), 4);

    // duplicate note-on, then release
    send(1'b1, 60, w);
    check("t3_dup_wait", w, 0);
    tick(1);
    check("t3_no_retrig", int'(voice_note_on), 0);
    check("t3_dup_count", int'(active_count), 4);
    off_q.push_back('{0, 60});
    send(1'b0, 60, w);
    check("t3_off_level", int'(voice_note_off[0]), 1);
    tick(3);
    check("t3_off_done", int'(voice_note_off[0]), 0);
    check("t3_count", int'(active_count), 3);

    // note-off before busy rises
    on_q.push_back('{0, 70});
    send(1'b1, 70, w);
    off_q.push_back('{0, 70});
    send(1'b0, 70, w);
    check("t4_still_start", int'(voice_note_on[0]), 1);
    tick(1);
    check("t4_rel_direct", int'(voice_note_off[0]), 1);
    check("t4_on_drop", int'(voice_note_on[0]), 0);
    send(1'b0, 99, w);
    check("t4_99_wait", w, 0);
    tick(4);
    check("t4_count", int'(active_count), 3);
    check("t4_off_idle", int'(voice_note_off), 0);

    // reset mid-operation
    off_q.push_back('{2, 64});
    send(1'b0, 64, w);
    @(negedge clk);
    #1 rst_b = 1'b0;
    #1;
    check("t5_note_on", int'(voice_note_on), 0);
    check("t5_note_off", int'(voice_note_off), 0);
    check("t5_key", int'(voice_key), 0);
    check("t5_count", int'(active_count), 0);
    tick(1);
    rst_b = 1'b1;
    tick(1);
    on_q.push_back('{0, 61});
    send(1'b1, 61, w);
    tick(3);
    check("t5_realloc_key", key_of(0), 61);
    check("t5_realloc_cnt", int'(active_count), 1);

`ifdef VOICE_ALLOC_STEAL_EN
    // steal the least recently allocated voice
    rst_b = 1'b0;
    tick(1);
    rst_b = 1'b1;
    tick(1);
    on_q.push_back('{0, 60});
    send(1'b1, 60, w);
    on_q.push_back('{1, 62});
    send(1'b1, 62, w);
    on_q.push_back('{2, 64});
    send(1'b1, 64, w);
    on_q.push_back('{3, 65});
    send(1'b1, 65, w);
    tick(3);
    off_q.push_back('{0, 60});
    on_q.push_back('{0, 72});
    send(1'b1, 72, w);
    check("t6_wait", w, 3);
    tick(3);
    check("t6_key0", key_of(0), 72);
    check("t6_count", int'(active_count), 4);
`endif

    tick(2);
    check("on_q_empty", on_q.size(), 0);
    check("off_q_empty", off_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
